// File: rtl/cam_sccb_arb.sv
// cam_sccb_arb: arbitrates init and runtime register writes onto one SCCB master with retry, timeout and bus-free gap
module cam_sccb_arb #(
   parameter int GAP_CYC     = 16,
   parameter int RETRY_MAX   = 2,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        pwr_done,
   input  logic        init_done,
   input  logic        init_start,
   input  logic [23:0] init_data,
   output logic        init_end,
   input  logic        rt_start,
   input  logic [23:0] rt_data,
   output logic        rt_end,
   output logic        sccb_start,
   output logic [23:0] sccb_data,
   input  logic        sccb_end,
   input  logic        sccb_nack,
   output logic        err,
   output logic        busy,
   output logic        ovf
);
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;

   state_t        state, state_nx;
   logic          init_full, rt_full, owner;
   logic [23:0]   init_buf, rt_buf;
   logic [GW-1:0] gap_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [RW-1:0] retry_cnt;
   logic          done, fail, retry, finish, issue_go, grant_rt;
   logic          clr_init, clr_rt, acc_init, acc_rt;

   assign done       = state == BUSY && sccb_end && !sccb_nack;
   assign fail       = state == BUSY && ((sccb_end && sccb_nack) || tmo_cnt == TW'(TIMEOUT_CYC));
   assign retry      = fail && retry_cnt != RW'(RETRY_MAX);
   assign finish     = done || (fail && !retry);
   assign issue_go   = state == IDLE && pwr_done && gap_cnt == '0 && (init_full || rt_full);
   assign grant_rt   = rt_full && (!init_full || (init_done && !owner));
   assign clr_init   = finish && !owner;
   assign clr_rt     = finish && owner;
   assign acc_init   = init_start && (!init_full || clr_init);
   assign acc_rt     = rt_start && (!rt_full || clr_rt);
   assign sccb_start = state == ISSUE;
   assign busy       = state != IDLE;

   // next state: a retry leaves GAP straight into ISSUE, otherwise back to IDLE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = issue_go ? ISSUE : IDLE;
         ISSUE:   state_nx = BUSY;
         BUSY:    state_nx = (done || fail) ? GAP : BUSY;
         GAP:     state_nx = (gap_cnt != '0) ? GAP : (retry_cnt != '0) ? ISSUE : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state <= IDLE;
      else state <= state_nx;
   end

   // gap counter doubles as the post-reset hold-off; timeout and retry counters
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         gap_cnt   <= GW'(GAP_CYC);
         tmo_cnt   <= '0;
         retry_cnt <= '0;
      end else begin
         gap_cnt   <= (state == BUSY && state_nx == GAP) ? GW'(GAP_CYC - 1) :
                      (gap_cnt != '0) ? gap_cnt - GW'(1) : gap_cnt;
         tmo_cnt   <= (state == ISSUE) ? '0 :
                      (state == BUSY && tmo_cnt != TW'(TIMEOUT_CYC)) ? tmo_cnt + TW'(1) : tmo_cnt;
         retry_cnt <= finish ? '0 : retry ? retry_cnt + RW'(1) : retry_cnt;
      end
   end

   // owner and write word latched at grant; end pulses and err one cycle after the outcome
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         owner     <= 1'b0;
         sccb_data <= '0;
         init_end  <= 1'b0;
         rt_end    <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (issue_go) begin
            owner     <= grant_rt;
            sccb_data <= grant_rt ? rt_buf : init_buf;
         end
         init_end <= clr_init;
         rt_end   <= clr_rt;
         err      <= finish && fail;
      end
   end

   // pending slots: a new start beats a same-cycle clear, a start into a busy slot is dropped
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         init_full <= 1'b0;
         rt_full   <= 1'b0;
         init_buf  <= '0;
         rt_buf    <= '0;
         ovf       <= 1'b0;
      end else begin
         init_full <= init_start || (init_full && !clr_init);
         rt_full   <= rt_start || (rt_full && !clr_rt);
         if (acc_init) init_buf <= init_data;
         if (acc_rt) rt_buf <= rt_data;
         ovf <= ovf || (init_start && !acc_init) || (rt_start && !acc_rt);
      end
   end
endmodule

// File: tb/tb_cam_sccb_arb.sv
// tb_cam_sccb_arb: randomized bench against a timestamp-based model of the arbiter
module tb_cam_sccb_arb;
   localparam int GAP = 4, RMAX = 2, TMO = 100;

   logic        sys_clk = 0, sys_rst = 1, pwr_done = 0, init_done = 0;
   logic        init_start = 0, rt_start = 0, sccb_end = 0, sccb_nack = 0;
   logic [23:0] init_data = 0, rt_data = 0, sccb_data;
   logic        init_end, rt_end, sccb_start, err, busy, ovf;

   cam_sccb_arb #(.GAP_CYC(GAP), .RETRY_MAX(RMAX), .TIMEOUT_CYC(TMO)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .pwr_done(pwr_done), .init_done(init_done),
      .init_start(init_start), .init_data(init_data), .init_end(init_end),
      .rt_start(rt_start), .rt_data(rt_data), .rt_end(rt_end),
      .sccb_start(sccb_start), .sccb_data(sccb_data), .sccb_end(sccb_end),
      .sccb_nack(sccb_nack), .err(err), .busy(busy), .ovf(ovf)
   );

   always #5 sys_clk = ~sys_clk;

   int n_chk = 0, n_pass = 0, cyc = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
   endtask

   // model: pending slots plus timestamps of the next expected events
   bit          mp[2], movf, infl, rnack, tmo_mode, rnd_on, f_init, f_rt;
   logic [23:0] md[2], xdata, f_idata, f_rdata;
   int          last, own, tries, t_issue, t_start0, t_resp, t_free, gap_end;
   bit          x_iend, x_rend, x_err;
   int          p_req = 0, nack_pct = 0, spur_pct = 0;

   task automatic model_reset();
      mp = '{0, 0}; movf = 0; infl = 0; last = 0; tries = 0; own = 0;
      t_issue = -1; t_start0 = -1; t_resp = -1; gap_end = -1;
      t_free = cyc + GAP; xdata = 0; x_iend = 0; x_rend = 0; x_err = 0;
   endtask

   task automatic tick();
      bit          is, rs, se, sn, good, bad;
      bit          clr[2];
      logic [23:0] id, rd;
      check("sccb_start", sccb_start, infl && cyc == t_issue);
      check("sccb_data", sccb_data, xdata);
      check("init_end", init_end, x_iend);
      check("rt_end", rt_end, x_rend);
      check("err", err, x_err);
      check("busy", busy, (infl && cyc >= t_start0) || cyc <= gap_end);
      check("ovf", ovf, movf);
      is = f_init || (rnd_on && $urandom_range(99) < p_req);
      rs = f_rt || (rnd_on && $urandom_range(99) < p_req);
      id = f_init ? f_idata : 24'($urandom);
      rd = f_rt ? f_rdata : 24'($urandom);
      f_init = 0; f_rt = 0;
      if (infl && cyc == t_issue) begin
         t_resp = tmo_mode ? -1 : cyc + 1 + $urandom_range(4);
         rnack = $urandom_range(99) < nack_pct;
      end
      se = infl && cyc == t_resp;
      sn = se ? rnack : 1'($urandom_range(1));
      if (!se && !tmo_mode && !(infl && cyc > t_issue) && $urandom_range(99) < spur_pct) se = 1;
      init_start = is; init_data = id; rt_start = rs; rt_data = rd;
      sccb_end = se; sccb_nack = sn;
      x_iend = 0; x_rend = 0; x_err = 0; clr = '{0, 0};
      if (infl && cyc > t_issue) begin
         good = se && !sn;
         bad = (se && sn) || cyc == t_issue + 1 + TMO;
         if (bad && tries <= RMAX) begin
            tries++;
            t_issue = cyc + GAP + 1;
         end else if (good || bad) begin
            x_iend = own == 0; x_rend = own == 1; x_err = bad;
            clr[own] = 1; infl = 0;
            gap_end = cyc + GAP; t_free = cyc + GAP + 1;
         end
      end else if (!infl && cyc >= t_free && pwr_done && (mp[0] || mp[1])) begin
         own = (mp[0] && mp[1]) ? (init_done ? 1 - last : 0) : (mp[1] ? 1 : 0);
         last = own; infl = 1; tries = 1; xdata = md[own];
         t_issue = cyc + 1; t_start0 = cyc + 1;
      end
      for (int p = 0; p < 2; p++) begin
         if (p ? rs : is) begin
            if (!mp[p] || clr[p]) begin mp[p] = 1; md[p] = p ? rd : id; end
            else movf = 1;
         end else if (clr[p]) mp[p] = 0;
      end
      cyc++;
      @(negedge sys_clk);
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rnd_on = 0; tmo_mode = 0; f_init = 0; f_rt = 0;
      repeat (3) @(negedge sys_clk);
      sys_rst = 0; model_reset();
      // issue held off until power is up
      f_init = 1; f_idata = 24'h310311;
      run(12);
      pwr_done = 1;
      run(30);
      // simultaneous requests, fixed priority then round-robin
      for (int k = 0; k < 2; k++) begin
         init_done = 1'(k);
         for (int r = 0; r < 2; r++) begin
            f_init = 1; f_idata = 24'($urandom); f_rt = 1; f_rdata = 24'($urandom);
            run(40);
         end
      end
      // NACK retries
      nack_pct = 70;
      for (int r = 0; r < 4; r++) begin f_rt = 1; f_rdata = 24'($urandom); run(50); end
      // overflow: second start while the slot is still pending
      nack_pct = 0;
      f_rt = 1; f_rdata = 24'hABCDEF; tick();
      f_rt = 1; f_rdata = 24'h123456; run(30);
      // random traffic
      rnd_on = 1; p_req = 12; nack_pct = 30; spur_pct = 10;
      init_done = 0; run(400);
      init_done = 1; run(400);
      for (int r = 0; r < 15; r++) begin pwr_done = 1'($urandom_range(1)); run(20); end
      pwr_done = 1; run(60);
      // timeouts: three attempts then err
      rnd_on = 0; run(40);
      tmo_mode = 1; f_rt = 1; f_rdata = 24'h55AA55;
      run(3 * (TMO + GAP + 3) + 20);
      tmo_mode = 0;
      // reset while BUSY
      f_init = 1; f_idata = 24'h0F0F0F;
      for (int i = 0; i < 30 && !(infl && cyc > t_issue + 1); i++) tick();
      check("reached_busy", infl && cyc > t_issue, 1);
      sys_rst = 1; init_start = 0; rt_start = 0; sccb_end = 0;
      #1;
      check("rst_sccb_start", sccb_start, 0);
      check("rst_sccb_data", sccb_data, 0);
      check("rst_init_end", init_end, 0);
      check("rst_rt_end", rt_end, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", ovf, 0);
      repeat (2) @(negedge sys_clk);
      sys_rst = 0; model_reset();
      f_rt = 1; f_rdata = 24'h777777; run(30);
      rnd_on = 1; run(200);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
